fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Read-side companion of the team's synchronous FIFO (ports DATAOUT/full/empty/wn/rn/DATAIN).
- Drives the FIFO read strobe, accounts for the FIFO's one-cycle registered read latency, and re-presents the popped words on a valid/ready stream with a 2-entry skid buffer.
- Adds packet framing (last flag every PKT_LEN words) and a transfer counter.
- Sits between the FIFO and any downstream consumer (serializer, checker).

Parameters:
DATA_WIDTH, 8, width of FIFO word and stream data
PKT_LEN, 4, words per packet; m_last marks the final word; legal range 1..255
CNT_WIDTH, 16, width of transfer counter

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clock)
enable  input  1  1 = issue FIFO reads; 0 = stop new reads, keep draining held data
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DATA_WIDTH  FIFO read data, valid one cycle after the accepted read
fifo_rn  output  1  FIFO read strobe (combinational)
m_data  output  DATA_WIDTH  stream data
m_valid  output  1  stream data valid
m_last  output  1  last word of packet, qualified by m_valid
m_ready  input  1  downstream accept
xfer_count  output  CNT_WIDTH  number of completed stream transfers, wraps

Behaviour:
- Reset (reset==0 at edge): skid buffer count=0, inflight=0, packet index=0, xfer_count=0. m_valid=0, m_last=0, m_data=0. fifo_rn is forced 0 while reset==0.
- Transfer: a transfer occurs on an edge where m_valid && m_ready. pop = m_valid && m_ready.
- Read accepted: fifo_rn high at an edge with fifo_empty low. Set inflight<=1 for the next cycle, else 0.
- Capture: when inflight==1, fifo_dout is written into the buffer on the next edge. The FIFO read latency is exactly 1 cycle.
- Read issue rule: fifo_rn = reset && enable && !fifo_empty && (count + inflight - pop) < 2. fifo_rn is combinational from fifo_empty and m_ready.
- Guarantee: the buffer never exceeds 2 entries, and no captured word is ever dropped.
- Buffer: 2-entry FIFO order. m_data/m_valid come from the head entry.
  - m_data holds stable while m_valid && !m_ready.
  - Simultaneous capture and pop in the same cycle is legal. Count is unchanged and ordering is preserved.
- Throughput: with the FIFO non-empty and m_ready held 1, one transfer per cycle after 2-cycle startup latency (read edge, capture edge, m_valid high after capture).
- Packet index: counts 0..PKT_LEN-1 and advances on each transfer.
  - m_last = m_valid && (index == PKT_LEN-1).
  - Index wraps to 0 after the last word.
  - PKT_LEN==1 gives m_last on every word.
- xfer_count: +1 per transfer, wraps at 2^CNT_WIDTH.
- enable low: fifo_rn=0 from that cycle. An in-flight word is still captured, and buffered words still drain. Packet index is not reset.
- FIFO goes empty: fifo_rn drops in the same cycle. The final read's data is still captured.
- Reset mid-operation: buffer and in-flight word are discarded. Index and count are cleared. Discarded words are not re-read.
- Reading an empty FIFO never occurs (fifo_rn gated by fifo_empty).

Test Plan:
1. Hold reset=0 for 2 edges with the FIFO holding data and enable=1 -> fifo_rn=0 throughout; m_valid=0, m_last=0, m_data=0, xfer_count=0.
2. Preload team FIFO with 100,150,200,40,70,65,15; enable=1, m_ready=1 -> stream carries 100,150,200,40,70,65,15 in order.
   - m_last only on 40.
   - xfer_count=7.
   - fifo_rn stays 0 once fifo_empty=1.
   - m_valid=0 afterward.
3. Preload 8 words (1..8), m_ready=1 -> after first m_valid, 8 transfers on 8 consecutive edges; m_last on 4 and 8; xfer_count=8.
4. Preload 1..8, m_ready=0 for 6 cycles then 1 -> exactly 2 FIFO reads during stall.
   - m_data=1 stable while stalled.
   - All 8 words then arrive in order with no loss or duplication.
5. Preload 1..8, drop enable after 3rd transfer for 5 cycles -> at most 2 further words appear, then m_valid=0 with FIFO non-empty.
   - On re-enable, remaining words continue in order.
   - m_last still on 4 and 8.
6. Preload 1..8, assert reset=0 for one edge after 2nd transfer -> m_valid=0, xfer_count=0, index=0.
   - Next word out is the FIFO's next unread word (not 3 if 3 was in buffer).
   - m_last on the 4th post-reset transfer.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side adapter: read strobe, 2-entry skid buffer, packet framing, transfer count
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rn,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    logic [1:0]            count;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [7:0]            pkt_idx;
    logic [CNT_WIDTH-1:0]  xfer_q;
    logic                  pop;
    logic [2:0]            occupancy;

    assign m_valid = (count != 2'd0);
    assign pop     = m_valid && m_ready;

    // Slots already promised: held words plus the word still coming out of the FIFO, less the one leaving now.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rn   = reset && enable && !fifo_empty && (occupancy < 3'd2);

    assign m_data     = m_valid ? head_q : '0;
    assign m_last     = m_valid && (pkt_idx == LAST_IDX);
    assign xfer_count = xfer_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            pkt_idx  <= 8'd0;
            xfer_q   <= '0;
        end else begin
            inflight <= fifo_rn;

            case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_q <= fifo_dout;
                    end else begin
                        tail_q <= fifo_dout;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: occupancy unchanged, order kept by shifting first.
                    if (count == 2'd1) begin
                        head_q <= fifo_dout;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= fifo_dout;
                    end
                end
                default: begin
                end
            endcase

            if (pop) begin
                xfer_q  <= xfer_q + 1'b1;
                pkt_idx <= (pkt_idx == LAST_IDX) ? 8'd0 : pkt_idx + 8'd1;
            end
        end
    end

endmodule
